// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road signal sequencer GA->YA->GB->YB with pedestrian cut,
// enable hold and a night-mode yellow flash.
module traffic_phase_ctrl #(
    parameter int DW         = 7,
    parameter int T_GA       = 40,
    parameter int T_YA       = 5,
    parameter int T_GB       = 20,
    parameter int T_YB       = 5,
    parameter int T_PED      = 10,
    parameter int FLASH_HALF = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          night,
    input  logic          ped_req,
    output logic [2:0]    state,
    output logic [DW-1:0] remain,
    output logic [2:0]    light_a,
    output logic [2:0]    light_b,
    output logic          phase_end
);
    if (T_GA < 1 || T_GA > 2**DW || T_YA < 1 || T_YA > 2**DW ||
        T_GB < 1 || T_GB > 2**DW || T_YB < 1 || T_YB > 2**DW ||
        T_PED < 1 || T_PED > 2**DW || FLASH_HALF < 1 || FLASH_HALF > 2**DW) begin : g_bad_param
        $fatal(1, "traffic_phase_ctrl: phase length parameter out of range for DW");
    end

    localparam logic [DW-1:0] L_GA  = DW'(T_GA - 1);
    localparam logic [DW-1:0] L_YA  = DW'(T_YA - 1);
    localparam logic [DW-1:0] L_GB  = DW'(T_GB - 1);
    localparam logic [DW-1:0] L_YB  = DW'(T_YB - 1);
    localparam logic [DW-1:0] L_PED = DW'(T_PED - 1);
    localparam logic [DW-1:0] L_FH  = DW'(FLASH_HALF - 1);

    typedef enum logic [2:0] {GA = 3'd0, YA = 3'd1, GB = 3'd2, YB = 3'd3, FLASH = 3'd4} st_t;

    st_t           st, st_nx;
    logic [DW-1:0] rem_nx;
    logic          blink, blink_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= GA;
            remain <= L_GA;
            blink  <= 1'b0;
        end else begin
            st     <= st_nx;
            remain <= rem_nx;
            blink  <= blink_nx;
        end
    end

    // Priority: night, leaving FLASH / illegal codes, en hold, phase advance, pedestrian cut.
    always_comb begin
        st_nx     = st;
        rem_nx    = remain;
        blink_nx  = blink;
        phase_end = 1'b0;
        if (night) begin
            st_nx = FLASH;
            if (st != FLASH) begin
                rem_nx = L_FH;
            end else begin
                rem_nx   = (remain == '0) ? L_FH : remain - 1'b1;
                blink_nx = (remain == '0) ? ~blink : blink;
            end
        end else if (st == FLASH || st > YB) begin
            st_nx    = GA;
            rem_nx   = L_GA;
            blink_nx = 1'b0;
        end else if (en) begin
            if (remain == '0) begin
                phase_end = 1'b1;
                st_nx     = (st == GA) ? YA : (st == YA) ? GB : (st == GB) ? YB : GA;
                rem_nx    = (st == GA) ? L_YA : (st == YA) ? L_GB : (st == GB) ? L_YB : L_GA;
            end else if (ped_req && (st == GA || st == GB) && remain > L_PED) begin
                rem_nx = L_PED;
            end else begin
                rem_nx = remain - 1'b1;
            end
        end
    end

    // Unused encodings show all-red on both roads until recovery.
    always_comb begin
        light_a = (st == GA) ? 3'b001 : (st == YA) ? 3'b010 :
                  (st == FLASH) ? {1'b0, blink, 1'b0} : 3'b100;
        light_b = (st == GB) ? 3'b001 : (st == YB) ? 3'b010 :
                  (st == FLASH) ? {1'b0, blink, 1'b0} : 3'b100;
    end

    assign state = st;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed and random stimulus against a phase-table reference model.
module tb_traffic_phase_ctrl;
    localparam int DW   = 7;
    localparam int TPED = 10;
    localparam int FH   = 4;

    int dur[4] = '{40, 5, 20, 5};

    logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, night = 1'b0, ped_req = 1'b0;
    logic [2:0]    state, light_a, light_b;
    logic [DW-1:0] remain;
    logic          phase_end;

    int errors = 0, checks = 0, pe_cnt = 0;
    int ph, left, fcnt;
    bit fl, bk;

    traffic_phase_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .night(night), .ped_req(ped_req),
        .state(state), .remain(remain), .light_a(light_a), .light_b(light_b),
        .phase_end(phase_end)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Road B sees the same lamp sequence as road A, shifted by two phases.
    function automatic logic [2:0] lamp(input bit road_b);
        int p;
        p = road_b ? (ph + 2) % 4 : ph;
        if (fl) return {1'b0, bk, 1'b0};
        return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
    endfunction

    task automatic model_reset();
        ph = 0; left = dur[0]; fl = 0; bk = 0; fcnt = 0;
    endtask

    task automatic check_outs();
        chk("state", 32'(state), fl ? 4 : ph);
        chk("remain", 32'(remain), fl ? fcnt : left - 1);
        chk("light_a", 32'(light_a), 32'(lamp(0)));
        chk("light_b", 32'(light_b), 32'(lamp(1)));
    endtask

    task automatic step(input bit e, input bit n, input bit p);
        en = e; night = n; ped_req = p;
        #2;
        chk("phase_end", 32'(phase_end), 32'(!fl && e && !n && left == 1));
        if (phase_end === 1'b1) pe_cnt++;
        @(posedge clk);
        if (n) begin
            if (!fl) begin fl = 1; fcnt = FH - 1; end
            else if (fcnt == 0) begin fcnt = FH - 1; bk = !bk; end
            else fcnt--;
        end else if (fl) begin
            fl = 0; ph = 0; left = dur[0]; bk = 0;
        end else if (e) begin
            if (left == 1) begin ph = (ph + 1) % 4; left = dur[ph]; end
            else if (p && ph % 2 == 0 && left > TPED) left = TPED;
            else left--;
        end
        #1;
        check_outs();
    endtask

    initial begin
        int n;
        bit nt;
        model_reset();
        @(posedge clk);
        #1;
        check_outs();
        chk("rst_phase_end", 32'(phase_end), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs();

        pe_cnt = 0;
        repeat (140) step(1, 0, 0);
        chk("pe_count_140", pe_cnt, 8);

        repeat (9) step(1, 0, 0);
        chk("ped_pre", 32'(remain), 30);
        step(1, 0, 1);
        chk("ped_cut", 32'(remain), 9);
        repeat (4) step(1, 0, 0);
        step(1, 0, 1);
        chk("ped_late", 32'(remain), 4);
        n = 0;
        while (ph != 1 && n < 50) begin step(1, 0, 0); n++; end
        chk("ya_after_cut", n, 5);

        n = 0;
        while (ph != 2 && n < 50) begin step(1, 0, 0); n++; end
        repeat (8) step(1, 0, 0);
        repeat (7) step(0, 0, 0);
        n = 0;
        while (ph != 3 && n < 50) begin step(1, 0, 0); n++; end
        chk("gb_tail_len", n, 12);

        n = 0;
        while (ph != 1 && n < 100) begin step(1, 0, 0); n++; end
        repeat (2) step(1, 0, 0);
        step(1, 1, 0);
        chk("night_entry", 32'(state), 4);
        repeat (12) step(0, 1, 0);
        step(0, 0, 0);
        chk("night_exit", 32'(remain), 39);

        n = 0;
        while (left != 1 && n < 100) begin step(1, 0, 0); n++; end
        step(1, 1, 0);
        step(1, 0, 0);

        n = 0;
        while (left != 1 && n < 100) begin step(1, 0, 0); n++; end
        step(1, 0, 1);
        chk("ped_at_end_state", 32'(state), 1);
        chk("ped_at_end_remain", 32'(remain), 4);

        n = 0;
        while (!(ph == 3 && left == 3) && n < 100) begin step(1, 0, 0); n++; end
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        chk("async_rst_phase_end", 32'(phase_end), 0);
        #2 rst_n = 1'b1;

        nt = 0;
        repeat (600) begin
            if ($urandom_range(0, 39) == 0) nt = !nt;
            step($urandom_range(0, 7) != 0, nt, $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter DW, default 7: width of the countdown counter `remain`.
REQ-002 Parameter T_GA, default 40: cycles spent in phase GA (road A green).
REQ-003 Parameter T_YA, default 5: cycles spent in phase YA (road A yellow).
REQ-004 Parameter T_GB, default 20: cycles spent in phase GB (road B green).
REQ-005 Parameter T_YB, default 5: cycles spent in phase YB (road B yellow).
REQ-006 Parameter T_PED, default 10: green-phase length after a pedestrian request cuts the phase short; must be at least 1.
REQ-007 Parameter FLASH_HALF, default 4: half-period, in cycles, of the yellow blink in night mode.
REQ-008 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-009 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-010 Port en, input, 1 bit: advance enable; when low the controller holds its state.
REQ-011 Port night, input, 1 bit: requests night (flash) mode.
REQ-012 Port ped_req, input, 1 bit: pedestrian request, sampled each cycle.
REQ-013 Port state, output, 3 bits: current phase: GA=0, YA=1, GB=2, YB=3, FLASH=4.
REQ-014 Port remain, output, DW bits: cycles left in the current phase, minus 1.
REQ-015 Port light_a, output, 3 bits: road A lamps as {red, yellow, green}.
REQ-016 Port light_b, output, 3 bits: road B lamps as {red, yellow, green}.
REQ-017 Port phase_end, output, 1 bit: one-cycle pulse on every normal phase advance.

Function
REQ-018 Each T_* parameter shall be at least 1 and at most 2^DW, and T_PED shall be at most 2^DW; violations shall stop elaboration.
REQ-019 On entering phase P, remain shall load T_P-1; remain shall then decrement by 1 each cycle in which en=1.
REQ-020 In a cycle where en=1, remain=0 and state is not FLASH, the controller shall step through the sequence GA->YA->GB->YB->GA and pulse phase_end high for that cycle.
REQ-021 Lamp outputs, driven from registered state only:
- GA: light_a=001, light_b=100.
- YA: light_a=010, light_b=100.
- GB: light_a=100, light_b=001.
- YB: light_a=100, light_b=010.
REQ-022 Pedestrian cut: when ped_req=1, en=1, state is GA or GB, and remain > T_PED-1, remain shall load T_PED-1 instead of decrementing.
REQ-023 Pedestrian requests shall have no effect in YA, YB or FLASH, or when remain <= T_PED-1; requests are not latched.
REQ-024 Night entry: night=1 shall move the controller to FLASH on the next edge, independent of en and of the current phase.
REQ-025 In FLASH, remain shall run as the blink counter, counting FLASH_HALF-1 down to 0.
REQ-026 In FLASH, a blink bit shall toggle each time the blink counter wraps.
REQ-027 In FLASH, light_a and light_b shall both equal {0, blink, 0}.
REQ-028 In FLASH, phase_end shall stay 0.
REQ-029 Night exit: in FLASH, night=0 shall move the controller on the next edge to GA with remain=T_GA-1 and blink=0.
REQ-030 Priority for simultaneous events: night first, then en=0 (hold), then phase advance at remain=0, then pedestrian cut.
REQ-031 FLASH state does not require en, and the blink runs in FLASH even when en=0.
REQ-032 Unused state encodings 5-7 shall recover to GA with remain=T_GA-1 on the next edge.

Reset
REQ-033 rst_n=0 shall immediately force:
- state=GA (0), remain=T_GA-1, blink=0, phase_end=0.
- light_a=001, light_b=100.
REQ-034 Reset asserted mid-phase or mid-FLASH shall discard all progress.
REQ-035 After rst_n rises, the first edge with en=1 shall decrement remain.

Verification
REQ-036 Defaults, en=1, night=0, ped_req=0, run 140 cycles:
- Phase entries fall at cycles 0/40/45/65/70/110.
- phase_end pulses exactly 4 times per 70-cycle period.
- Lamp codes match REQ-021 throughout.
REQ-037 Pedestrian cut at remain=30 in GA:
- ped_req=1 for 1 cycle -> remain=9 next cycle; YA entered 10 cycles later.
- A second ped_req at remain=5 -> no change.
REQ-038 en toggled low for 7 cycles mid-GB: remain and lamps hold; phase lengths otherwise unchanged.
REQ-039 night=1 during YA:
- Next edge: state=4, both lamps alternate 010/000 every 4 cycles.
- night=0: next state=0, remain=39.
REQ-040 rst_n pulsed low asynchronously mid-YB (between edges) -> outputs return to REQ-033 values before the next edge.
REQ-041 Simultaneous night=1 and remain=0 -> FLASH, no phase_end pulse.
REQ-042 Simultaneous ped_req=1 and remain=0 in GA -> YA with remain=4.
